// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 bus responder.
//   - bus_t       : one sampled bus beat (EN, RS, RW, DATA)
//   - state_e     : controller state (idle / power-on or commanded clear / busy)
//   - op_e        : command class, found by the position of the leading one
//   - decode_cmd  : command byte -> op_e
//   - idx_to_ac   : shadow index 0..31 -> HD44780 address counter value
package lcd_pkg;

  localparam int BUSY_SHORT_DEF = 2000;   // 40 us at 50 MHz
  localparam int BUSY_LONG_DEF  = 82000;  // 1.64 ms at 50 MHz

  localparam logic [7:0] SPACE      = 8'h20;
  localparam logic [6:0] LINE2_BASE = 7'h40;

  // Command classes: the leading one of the byte selects the instruction.
  localparam logic [7:0] MASK_DDRAM   = 8'h80, VAL_DDRAM   = 8'h80;
  localparam logic [7:0] MASK_CGRAM   = 8'hC0, VAL_CGRAM   = 8'h40;
  localparam logic [7:0] MASK_FUNC    = 8'hE0, VAL_FUNC    = 8'h20;
  localparam logic [7:0] MASK_SHIFT   = 8'hF0, VAL_SHIFT   = 8'h10;
  localparam logic [7:0] MASK_DISPLAY = 8'hF8, VAL_DISPLAY = 8'h08;
  localparam logic [7:0] MASK_ENTRY   = 8'hFC, VAL_ENTRY   = 8'h04;
  localparam logic [7:0] MASK_HOME    = 8'hFE, VAL_HOME    = 8'h02;
  localparam logic [7:0] MASK_CLEAR   = 8'hFF, VAL_CLEAR   = 8'h01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_BUSY  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE,      // 0x00: accepted, no effect
    OP_CLEAR,
    OP_HOME,
    OP_ENTRY,
    OP_DISPLAY,
    OP_NOEFFECT,  // cursor shift, function set, CGRAM address
    OP_DDRAM
  } op_e;

  typedef struct packed {
    logic       en;
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } bus_t;

  function automatic op_e decode_cmd(input logic [7:0] b);
    if      ((b & MASK_DDRAM)   == VAL_DDRAM)   return OP_DDRAM;
    else if ((b & MASK_CGRAM)   == VAL_CGRAM)   return OP_NOEFFECT;
    else if ((b & MASK_FUNC)    == VAL_FUNC)    return OP_NOEFFECT;
    else if ((b & MASK_SHIFT)   == VAL_SHIFT)   return OP_NOEFFECT;
    else if ((b & MASK_DISPLAY) == VAL_DISPLAY) return OP_DISPLAY;
    else if ((b & MASK_ENTRY)   == VAL_ENTRY)   return OP_ENTRY;
    else if ((b & MASK_HOME)    == VAL_HOME)    return OP_HOME;
    else if ((b & MASK_CLEAR)   == VAL_CLEAR)   return OP_CLEAR;
    else                                        return OP_NONE;
  endfunction

  function automatic logic [6:0] idx_to_ac(input logic [4:0] idx);
    return idx[4] ? (LINE2_BASE | {3'b000, idx[3:0]}) : {3'b000, idx[3:0]};
  endfunction

endpackage

// File: rtl/lcd_ddram_shadow.sv
// 32x8 DDRAM shadow (index 0-15 line 1, 16-31 line 2).
//   clock, reset       : clock, async active-low reset (read register only)
//   we_i/waddr_i/wdata_i : synchronous write port
//   rd_addr_i -> rd_data_o : registered read port, 1 clock latency; a write to
//                            the same index in the same clock returns old data
//   bus_addr_i -> bus_rdata_o : combinational read port for bus data reads
module lcd_ddram_shadow (
  input  logic       clock,
  input  logic       reset,
  input  logic       we_i,
  input  logic [4:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [4:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  input  logic [4:0] bus_addr_i,
  output logic [7:0] bus_rdata_o
);

  logic [7:0] mem_q [32];

  // NOTE: the array has no reset; a reset would turn it into 256 flops with
  // reset muxes. Its contents are defined by the power-on clear sequence instead.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_data_o <= 8'h00;
    else        rd_data_o <= mem_q[rd_addr_i];
  end

  assign bus_rdata_o = mem_q[bus_addr_i];

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Device end of an 8-bit HD44780 bus: decodes EN/RS/RW/LCD_DATA cycles into a
// 2x16 DDRAM shadow and models the busy flag.
//   clock, reset (async, active-low)
//   LCD_EN/LCD_RS/LCD_RW : bus controls; synced EN falling edge commits a cycle
//   LCD_DATA             : bidirectional; driven while synced RW=1 and EN=1
//   rd_addr -> rd_char   : shadow read, 1 clock latency
//   busy                 : busy flag (BF)
//   cmd_valid, cmd_byte  : pulse and byte for each accepted command write
//   disp_on              : display-control D bit
//   overrun, addr_err    : sticky error flags
module lcd_hd44780_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_SHORT  = BUSY_SHORT_DEF,
  parameter int BUSY_LONG   = BUSY_LONG_DEF,
  parameter int SYNC_STAGES = 2              // must be >= 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       LCD_EN,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  inout  wire  [7:0] LCD_DATA,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       busy,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       disp_on,
  output logic       overrun,
  output logic       addr_err
);

  localparam int CW = (BUSY_LONG > 0) ? $clog2(BUSY_LONG + 1) : 1;
  localparam logic [CW-1:0] LOAD_SHORT = CW'(BUSY_SHORT);
  localparam logic [CW-1:0] LOAD_LONG  = CW'(BUSY_LONG);

  // ---------------- input synchroniser and commit detect ----------------
  bus_t [SYNC_STAGES-1:0] sync_q;
  bus_t                   bus_s;
  logic                   en_prev_q;

  // NOTE: every register uses <= so all flops update from pre-edge values,
  // which is what makes the shift chain below a real multi-stage pipeline.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      en_prev_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], LCD_EN, LCD_RS, LCD_RW, LCD_DATA};
      en_prev_q <= bus_s.en;
    end
  end

  assign bus_s = sync_q[SYNC_STAGES-1];

  // ---------------- controller state ----------------
  state_e        state_q;
  logic          busy_q, id_q, disp_on_q, overrun_q, addr_err_q, cmd_valid_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    clr_idx_q, cursor_q, next_cursor;
  logic [7:0]    cmd_byte_q;

  logic    commit, status_rd, accept, advance, data_wr, cmd_wr;
  logic    go_clear, load_en;
  logic [CW-1:0] load_val;
  op_e     op;
  logic [6:0] ddram_a;

  assign commit    = en_prev_q & ~bus_s.en;
  assign status_rd = bus_s.rw & ~bus_s.rs;        // never busy-gated, no effect
  assign accept    = commit & ~status_rd & ~busy_q;
  assign advance   = accept & bus_s.rs;           // data write or data read
  assign data_wr   = advance & ~bus_s.rw;
  assign cmd_wr    = accept & ~bus_s.rs;          // status_rd excluded => RW=0
  assign op        = decode_cmd(bus_s.data);
  assign ddram_a   = bus_s.data[6:0];
  assign next_cursor = id_q ? cursor_q + 5'd1 : cursor_q - 5'd1;

  // Busy-counter loads. Only one source can be active: commits are accepted
  // in S_IDLE only, and the end-of-clear load happens in S_CLEAR only.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    go_clear = cmd_wr && (op == OP_CLEAR);
    load_en  = 1'b0;
    load_val = LOAD_SHORT;
    if (state_q == S_CLEAR && clr_idx_q == 5'd31) begin
      load_en  = 1'b1;
      load_val = LOAD_LONG;
    end else if (advance || (cmd_wr && op != OP_CLEAR)) begin
      load_en  = 1'b1;
      load_val = (cmd_wr && op == OP_HOME) ? LOAD_LONG : LOAD_SHORT;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_CLEAR;
      busy_q      <= 1'b1;
      cnt_q       <= '0;
      clr_idx_q   <= '0;
      cursor_q    <= '0;
      id_q        <= 1'b1;
      disp_on_q   <= 1'b0;
      overrun_q   <= 1'b0;
      addr_err_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= 8'h00;
    end else begin
      cmd_valid_q <= 1'b0;
      if (commit && !status_rd && busy_q) overrun_q <= 1'b1;
      if (state_q == S_CLEAR) clr_idx_q <= clr_idx_q + 5'd1;

      if (go_clear) begin
        state_q   <= S_CLEAR;
        busy_q    <= 1'b1;
        clr_idx_q <= '0;
      end else if (load_en) begin
        // A zero load means "no busy time": skip straight to idle.
        if (load_val == '0) begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end else begin
          state_q <= S_BUSY;
          busy_q  <= 1'b1;
          cnt_q   <= load_val;
        end
      end else if (state_q == S_BUSY) begin
        // Load N gives N clocks in S_BUSY.
        if (cnt_q <= CW'(1)) begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_q - CW'(1);
        end
      end

      if (advance) cursor_q <= next_cursor;

      if (cmd_wr) begin
        cmd_valid_q <= 1'b1;
        cmd_byte_q  <= bus_s.data;
        case (op)
          OP_CLEAR: begin
            cursor_q <= '0;
            id_q     <= 1'b1;
          end
          OP_HOME:    cursor_q  <= '0;
          OP_ENTRY:   id_q      <= bus_s.data[1];
          OP_DISPLAY: disp_on_q <= bus_s.data[2];
          OP_DDRAM: begin
            // 0x00-0x0F and 0x40-0x4F map onto the two 16-char lines.
            if (ddram_a[6:4] == 3'b000 || ddram_a[6:4] == 3'b100)
              cursor_q <= {ddram_a[6], ddram_a[3:0]};
            else
              addr_err_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- shadow RAM and bus read-back ----------------
  logic       mem_we;
  logic [4:0] mem_waddr;
  logic [7:0] mem_wdata, bus_rdata, bus_out;
  logic       bus_oe;

  assign mem_we    = (state_q == S_CLEAR) | data_wr;
  assign mem_waddr = (state_q == S_CLEAR) ? clr_idx_q : cursor_q;
  assign mem_wdata = (state_q == S_CLEAR) ? SPACE : bus_s.data;

  lcd_ddram_shadow u_shadow (
    .clock       (clock),
    .reset       (reset),
    .we_i        (mem_we),
    .waddr_i     (mem_waddr),
    .wdata_i     (mem_wdata),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_char),
    .bus_addr_i  (cursor_q),
    .bus_rdata_o (bus_rdata)
  );

  assign bus_oe   = bus_s.rw & bus_s.en;
  assign bus_out  = bus_s.rs ? bus_rdata : {busy_q, idx_to_ac(cursor_q)};
  assign LCD_DATA = bus_oe ? bus_out : 8'hzz;

  assign busy      = busy_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_byte  = cmd_byte_q;
  assign disp_on   = disp_on_q;
  assign overrun   = overrun_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Bench for lcd_hd44780_responder with short busy times. Expected values come
// from a screen-level model: a 32-entry character array, a cursor index and a
// handful of flags, updated from the HD44780 instruction rules.
module tb_lcd_hd44780_responder;

  localparam int SHORT = 16;
  localparam int LONG  = 40;
  localparam int SYNC  = 2;
  // Clocks from the bench's EN fall until busy reads 0: SYNC stages, one clock
  // to act on the commit, then the busy time itself.
  localparam int T_WR   = SYNC + 1 + SHORT;
  localparam int T_HOME = SYNC + 1 + LONG;
  localparam int T_CLR  = SYNC + 1 + 32 + LONG;
  localparam int T_POR  = 32 + LONG;

  logic       clock = 1'b0, reset = 1'b0;
  logic       lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0, tb_oe = 1'b1;
  logic [7:0] drv = 8'h00;
  wire  [7:0] lcd_data;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char, cmd_byte;
  logic       busy, cmd_valid, disp_on, overrun, addr_err;

  assign lcd_data = tb_oe ? drv : 8'hzz;

  lcd_hd44780_responder #(
    .BUSY_SHORT(SHORT), .BUSY_LONG(LONG), .SYNC_STAGES(SYNC)
  ) dut (
    .clock(clock), .reset(reset),
    .LCD_EN(lcd_en), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_DATA(lcd_data),
    .rd_addr(rd_addr), .rd_char(rd_char),
    .busy(busy), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .disp_on(disp_on), .overrun(overrun), .addr_err(addr_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int t_fall = 0, cv_hits = 0;
  logic [7:0] cv_byte, bus_seen;
  logic [7:0] dump [32];

  // ---------------- reference model ----------------
  logic [7:0] m_mem [32];
  int         m_cur;
  bit         m_id, m_disp, m_ovr, m_aerr;

  function automatic void m_power_on();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
    m_cur = 0; m_id = 1; m_disp = 0; m_ovr = 0; m_aerr = 0;
  endfunction

  function automatic void m_data(input logic [7:0] d);
    m_mem[m_cur] = d;
    m_cur = m_id ? (m_cur + 1) % 32 : (m_cur + 31) % 32;
  endfunction

  function automatic void m_cmd(input logic [7:0] d);
    int v, a;
    v = int'(d);
    if (v >= 128) begin
      a = v - 128;
      if (a < 16)                m_cur = a;
      else if (a >= 64 && a < 80) m_cur = 16 + (a - 64);
      else                        m_aerr = 1;
    end else if (v >= 16) begin
      // shift / function set / CGRAM address: nothing visible
    end else if (v >= 8) m_disp = d[2];
    else if (v >= 4)     m_id = d[1];
    else if (v >= 2)     m_cur = 0;
    else if (v == 1) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
      m_cur = 0; m_id = 1;
    end
  endfunction

  function automatic int m_cmd_time(input logic [7:0] d);
    if (d == 8'h01) return T_CLR;
    if (d == 8'h02 || d == 8'h03) return T_HOME;
    return T_WR;
  endfunction

  function automatic logic [7:0] m_status(input bit b);
    int ac;
    ac = (m_cur < 16) ? m_cur : 64 + m_cur - 16;
    return {b, 7'(ac)};
  endfunction

  // ---------------- bus driver ----------------
  task automatic bus_start(input bit rs_v, input bit rw_v, input logic [7:0] d);
    repeat (2) @(negedge clock);
    lcd_rs = rs_v; lcd_rw = rw_v; drv = d; tb_oe = !rw_v;
    repeat (2) @(negedge clock);
    lcd_en = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic bus_end();
    lcd_en = 1'b0;
    t_fall = cyc;
  endtask

  // Waits for busy to fall after the last EN fall; t = clocks since that fall.
  task automatic wait_busy_low(input string tag, output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (i >= SYNC + 2 && !busy) begin
        t = cyc - t_fall;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL %s: busy never dropped within 200 clocks", tag);
  endtask

  // Write cycle; records cmd_valid activity in the first clocks after the fall.
  task automatic bus_write(input bit rs_v, input logic [7:0] d, output int t);
    bus_start(rs_v, 1'b0, d);
    bus_seen = lcd_data;
    bus_end();
    cv_hits = 0; cv_byte = 8'h00;
    repeat (SYNC + 3) begin
      @(negedge clock);
      if (cmd_valid) begin cv_hits++; cv_byte = cmd_byte; end
    end
    t_fall = t_fall;  // measurement still relative to the EN fall
    wait_busy_low("write", t);
  endtask

  task automatic bus_read(input bit rs_v);
    bus_start(rs_v, 1'b1, 8'h00);
    bus_seen = lcd_data;
    bus_end();
    repeat (SYNC + 2) @(negedge clock);
  endtask

  task automatic dump_shadow();
    for (int i = 0; i < 32; i++) begin
      @(negedge clock); rd_addr = 5'(i);
      @(negedge clock); dump[i] = rd_char;
    end
  endtask

  task automatic cmd(input logic [7:0] d);
    int t;
    bus_write(1'b0, d, t);
    m_cmd(d);
    checks++;
    if (cv_hits !== 1 || cv_byte !== d) begin
      errors++;
      $display("FAIL cmd_valid %02h: pulses %0d byte %02h, want 1 pulse byte %02h", d, cv_hits, cv_byte, d);
    end
    checks++;
    if (t !== m_cmd_time(d)) begin
      errors++;
      $display("FAIL cmd_busy %02h: busy for %0d clocks, want %0d", d, t, m_cmd_time(d));
    end
  endtask

  task automatic wdata(input logic [7:0] d);
    int t;
    bus_write(1'b1, d, t);
    m_data(d);
    checks++;
    if (t !== T_WR || cv_hits !== 0) begin
      errors++;
      $display("FAIL data_busy %02h: busy %0d clocks cmd_valid %0d, want %0d and 0", d, t, cv_hits, T_WR);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int t;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, cmd_valid, cmd_byte, disp_on, overrun, addr_err, rd_char} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: busy %b cv %b cb %02h don %b ovr %b aerr %b rc %02h", busy, cmd_valid, cmd_byte, disp_on, overrun, addr_err, rd_char);
    end
    reset = 1'b1; t_fall = cyc;
    m_power_on();
    wait_busy_low("por", t);
    checks++;
    if (t !== T_POR) begin errors++; $display("FAIL por_busy: %0d clocks, want %0d", t, T_POR); end
    dump_shadow();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dump[i] !== 8'h20) begin errors++; $display("FAIL por_shadow[%0d]: %02h want 20", i, dump[i]); end
    end
  endtask

  task automatic test_vote();
    cmd(8'h38); cmd(8'h0C); cmd(8'h06);
    wdata("V"); wdata("O"); wdata("T"); wdata("E");
    checks++;
    if (disp_on !== 1'b1) begin errors++; $display("FAIL disp_on: %b want 1", disp_on); end
    dump_shadow();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dump[i] !== m_mem[i]) begin errors++; $display("FAIL vote[%0d]: %02h want %02h", i, dump[i], m_mem[i]); end
    end
  endtask

  task automatic test_line2_addr_err();
    cmd(8'hC0); wdata("A");
    cmd(8'hD0);
    checks++;
    if (addr_err !== 1'b1) begin errors++; $display("FAIL addr_err: %b want 1", addr_err); end
    bus_read(1'b0);
    checks++;
    if (bus_seen !== m_status(1'b0)) begin errors++; $display("FAIL ac_kept: %02h want %02h", bus_seen, m_status(1'b0)); end
    dump_shadow();
    checks++;
    if (dump[16] !== 8'h41) begin errors++; $display("FAIL line2_A: %02h want 41", dump[16]); end
  endtask

  task automatic test_wrap();
    cmd(8'hCF); wdata("Z"); wdata("Y");
    cmd(8'h04); cmd(8'h80); wdata("X");
    bus_read(1'b0);
    checks++;
    if (bus_seen !== 8'h4F) begin errors++; $display("FAIL wrap_down_ac: %02h want 4f", bus_seen); end
    cmd(8'h8F); cmd(8'h06); wdata("a"); wdata("b");
    dump_shadow();
    foreach (dump[i]) begin
      checks++;
      if (dump[i] !== m_mem[i]) begin errors++; $display("FAIL wrap_shadow[%0d]: %02h want %02h", i, dump[i], m_mem[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int tf, t;
    cmd(8'h8A);
    bus_start(1'b1, 1'b0, "Q"); bus_end(); tf = t_fall;
    bus_start(1'b1, 1'b0, "R"); bus_end();   // lands inside the busy window
    t_fall = tf;
    wait_busy_low("overrun", t);
    m_data("Q"); m_ovr = 1;
    checks++;
    if (t !== T_WR) begin errors++; $display("FAIL overrun_busy: %0d clocks want %0d", t, T_WR); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: %b want 1", overrun); end
    bus_read(1'b0);
    checks++;
    if (bus_seen !== m_status(1'b0)) begin errors++; $display("FAIL overrun_ac: %02h want %02h", bus_seen, m_status(1'b0)); end
    dump_shadow();
    checks++;
    if (dump[10] !== "Q" || dump[11] !== m_mem[11]) begin
      errors++; $display("FAIL overrun_shadow: %02h %02h want %02h %02h", dump[10], dump[11], m_mem[10], m_mem[11]);
    end
  endtask

  task automatic test_bus_reads();
    int t;
    // Data read returns shadow[cursor] and advances like a write.
    cmd(8'h80);
    bus_read(1'b1);
    checks++;
    if (bus_seen !== m_mem[0]) begin errors++; $display("FAIL data_read: %02h want %02h", bus_seen, m_mem[0]); end
    m_cur = 1;
    bus_read(1'b0);  // still busy from the data read
    checks++;
    if (bus_seen !== m_status(1'b1)) begin errors++; $display("FAIL status_busy: %02h want %02h", bus_seen, m_status(1'b1)); end
    wait_busy_low("rd", t);
    // Status read right after cmd 0xC5, then again once idle.
    bus_start(1'b0, 1'b0, 8'hC5); bus_end(); m_cmd(8'hC5);
    bus_read(1'b0);
    checks++;
    if (bus_seen !== 8'hC5) begin errors++; $display("FAIL status_c5_busy: %02h want c5", bus_seen); end
    wait_busy_low("c5", t);
    bus_read(1'b0);
    checks++;
    if (bus_seen !== 8'h45) begin errors++; $display("FAIL status_c5_idle: %02h want 45", bus_seen); end
    // During a write the responder must leave the bus to the bench.
    bus_write(1'b0, 8'h3A, t); m_cmd(8'h3A);
    checks++;
    if (bus_seen !== 8'h3A) begin errors++; $display("FAIL bus_release: %02h want 3a", bus_seen); end
  endtask

  task automatic test_home_clear();
    cmd(8'h02);
    bus_read(1'b0);
    checks++;
    if (bus_seen !== 8'h00) begin errors++; $display("FAIL home_ac: %02h want 00", bus_seen); end
    cmd(8'h01);
    dump_shadow();
    foreach (dump[i]) begin
      checks++;
      if (dump[i] !== 8'h20) begin errors++; $display("FAIL clear_shadow[%0d]: %02h want 20", i, dump[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0, 1: wdata(8'($urandom_range(33, 126)));
        2: begin
          if ($urandom_range(0, 7) == 0) d = 8'($urandom_range(128, 255));
          else begin
            d = 8'($urandom_range(0, 31));
            d = (d < 16) ? (8'h80 | d) : (8'hC0 | (d - 8'd16));
          end
          cmd(d);
        end
        default: cmd($urandom_range(0, 1) ? (8'h04 | 8'($urandom_range(0, 3)))
                                         : (8'h08 | 8'($urandom_range(0, 7))));
      endcase
    end
    bus_read(1'b0);
    checks++;
    if (bus_seen !== m_status(1'b0)) begin errors++; $display("FAIL rand_ac: %02h want %02h", bus_seen, m_status(1'b0)); end
    checks++;
    if ({disp_on, overrun, addr_err} !== {m_disp, m_ovr, m_aerr}) begin
      errors++; $display("FAIL rand_flags: %b%b%b want %b%b%b", disp_on, overrun, addr_err, m_disp, m_ovr, m_aerr);
    end
    dump_shadow();
    foreach (dump[i]) begin
      checks++;
      if (dump[i] !== m_mem[i]) begin errors++; $display("FAIL rand_shadow[%0d]: %02h want %02h", i, dump[i], m_mem[i]); end
    end
  endtask

  task automatic test_mid_reset();
    int t;
    bus_start(1'b1, 1'b0, "M"); bus_end();
    repeat (6) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, overrun, addr_err, disp_on, rd_char} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL mid_reset_state: busy %b ovr %b aerr %b don %b rc %02h", busy, overrun, addr_err, disp_on, rd_char);
    end
    @(negedge clock); @(negedge clock);
    reset = 1'b1; t_fall = cyc;
    m_power_on();
    wait_busy_low("mid_reset", t);
    checks++;
    if (t !== T_POR) begin errors++; $display("FAIL mid_reset_busy: %0d clocks want %0d", t, T_POR); end
    dump_shadow();
    foreach (dump[i]) begin
      checks++;
      if (dump[i] !== 8'h20) begin errors++; $display("FAIL mid_reset_shadow[%0d]: %02h want 20", i, dump[i]); end
    end
    bus_read(1'b0);
    checks++;
    if (bus_seen !== 8'h00) begin errors++; $display("FAIL mid_reset_ac: %02h want 00", bus_seen); end
  endtask

  initial begin
    test_reset();
    test_vote();
    test_line2_addr_err();
    test_wrap();
    test_back_to_back();
    test_bus_reads();
    test_home_clear();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
